// File: rtl/sw_inj.sv
`default_nettype none
// ============================================================================
// Module   : sw_inj
// Brief    : Payload FIFO plus head/body/tail framer feeding one switch input.
// Revision : 1.0 - initial release
// ============================================================================
module sw_inj #(
    parameter int DEPTH = 8,
    parameter int GAP   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr,
    input  logic [7:0] wdata,
    input  logic       req,
    input  logic [1:0] dst,
    input  logic [3:0] tag,
    output logic [9:0] pkt,
    output logic       full,
    output logic       busy
);

    localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNTW = $clog2(DEPTH + 1);
    localparam int GAPW = (GAP > 0) ? $clog2(GAP + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HEAD = 2'd1,
        S_DATA = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    state_t            r_state;
    logic [7:0]        r_mem [DEPTH];
    logic [PTRW-1:0]   r_rd_ptr;
    logic [PTRW-1:0]   r_wr_ptr;
    logic [CNTW-1:0]   r_count;
    logic [CNTW-1:0]   r_rem;
    logic [GAPW-1:0]   r_gap_cnt;
    logic [9:0]        r_pkt;
    logic              r_full;
    logic              r_busy;

    logic              w_push;
    logic              w_pop;
    logic [CNTW-1:0]   w_count_nxt;

    function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
        return (p == PTRW'(DEPTH - 1)) ? '0 : p + PTRW'(1);
    endfunction

    // A write while full is dropped even when a pop frees a slot this cycle.
    always_comb begin
        w_push      = wr && !r_full;
        w_pop       = ((r_state == S_HEAD) || (r_state == S_DATA)) && (r_rem != '0);
        w_count_nxt = r_count + CNTW'(w_push) - CNTW'(w_pop);
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CNTW'(DEPTH));
        end
    end

    // The flit shown on pkt always matches r_state; r_rem counts payload
    // flits still to be launched, so rem==0 in DATA means the tail is showing.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_pkt     <= '0;
            r_busy    <= 1'b0;
            r_rem     <= '0;
            r_gap_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_pkt <= '0;
                    if (req && (r_count != '0)) begin
                        r_pkt   <= {2'b10, tag, 2'b00, dst};
                        r_rem   <= r_count;
                        r_busy  <= 1'b1;
                        r_state <= S_HEAD;
                    end
                end
                S_HEAD, S_DATA: begin
                    if (r_rem != '0) begin
                        r_pkt   <= {(r_rem == CNTW'(1)) ? 2'b11 : 2'b01, r_mem[r_rd_ptr]};
                        r_rem   <= r_rem - CNTW'(1);
                        r_state <= S_DATA;
                    end else begin
                        r_pkt <= '0;
                        if (GAP > 0) begin
                            r_gap_cnt <= GAPW'(GAP);
                            r_state   <= S_GAP;
                        end else begin
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_GAP: begin
                    r_pkt <= '0;
                    if (r_gap_cnt <= GAPW'(1)) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - GAPW'(1);
                    end
                end
                default: begin
                    r_pkt   <= '0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign pkt  = r_pkt;
    assign full = r_full;
    assign busy = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_sw_inj.sv
`default_nettype none
// ============================================================================
// Module   : tb_sw_inj
// Brief    : Randomized and directed bench for sw_inj against a stream model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sw_inj;

    localparam int DEPTH = 8;
    localparam int GAP   = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr = 1'b0;
    logic [7:0] wdata = '0;
    logic       req = 1'b0;
    logic [1:0] dst = '0;
    logic [3:0] tag = '0;
    logic [9:0] pkt;
    logic       full;
    logic       busy;

    int total = 0;
    int bad   = 0;

    sw_inj #(.DEPTH(DEPTH), .GAP(GAP)) dut (
        .clk   (clk),
        .rst   (rst),
        .wr    (wr),
        .wdata (wdata),
        .req   (req),
        .dst   (dst),
        .tag   (tag),
        .pkt   (pkt),
        .full  (full),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    // Reference: FIFO as a byte queue, plus a queue of flits still to be shown.
    typedef struct {
        logic [9:0] p;
        logic       pop;
    } ent_t;

    logic [7:0] q[$];
    ent_t       oq[$];
    logic [9:0] e_pkt  = '0;
    logic       e_busy = 1'b0;
    logic       e_full = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        int   n_b;
        logic full_b;
        logic was_busy;
        ent_t e;
        if (rst) begin
            q.delete();
            oq.delete();
            e_pkt  = '0;
            e_busy = 1'b0;
            e_full = 1'b0;
            return;
        end
        n_b      = q.size();
        full_b   = (n_b == DEPTH);
        was_busy = e_busy;
        if (oq.size() > 0) begin
            e = oq.pop_front();
            if (e.pop) e_pkt = {e.p[9:8], q.pop_front()};
            else       e_pkt = e.p;
            e_busy = 1'b1;
        end else begin
            e_pkt  = '0;
            e_busy = 1'b0;
        end
        if (!was_busy && req && n_b > 0) begin
            e_pkt  = {2'b10, tag, 2'b00, dst};
            e_busy = 1'b1;
            for (int i = 0; i < n_b; i++) begin
                e.p   = {(i == n_b - 1) ? 2'b11 : 2'b01, 8'h00};
                e.pop = 1'b1;
                oq.push_back(e);
            end
            for (int i = 0; i < GAP; i++) begin
                e.p   = '0;
                e.pop = 1'b0;
                oq.push_back(e);
            end
        end
        if (wr && !full_b) q.push_back(wdata);
        e_full = (q.size() == DEPTH);
    endtask

    task automatic step(input logic s_wr, input logic [7:0] s_wd, input logic s_req,
                        input logic [1:0] s_dst, input logic [3:0] s_tag, input logic s_rst);
        @(negedge clk);
        wr = s_wr; wdata = s_wd; req = s_req; dst = s_dst; tag = s_tag; rst = s_rst;
        @(posedge clk);
        model_edge();
        #1;
        chk("pkt",  32'(pkt),  32'(e_pkt));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("full", 32'(full), 32'(e_full));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 2'd0, 4'd0, 1'b0);
    endtask

    task automatic push(input logic [7:0] b);
        step(1'b1, b, 1'b0, 2'd0, 4'd0, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && e_busy; i++) idle(1);
    endtask

    initial begin
        step(1'b0, 8'h00, 1'b0, 2'd0, 4'd0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 2'd0, 4'd0, 1'b1);
        chk("rst_pkt", 32'(pkt), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        idle(1);

        // Long packet
        push(8'h00); push(8'h01); push(8'h02);
        step(1'b0, 8'h00, 1'b1, 2'd1, 4'd9, 1'b0);
        chk("long_head", 32'(pkt), 32'(10'b10_1001_0001));
        idle(3);
        chk("long_tail", 32'(pkt), 32'(10'b11_0000_0010));
        idle(4);

        // Short packets to every destination
        for (int d = 0; d < 4; d++) begin
            push(8'h0F);
            step(1'b0, 8'h00, 1'b1, 2'(d), 4'(d), 1'b0);
            idle(1);
            chk("short_tail", 32'(pkt), 32'(10'b11_0000_1111));
            idle(3);
        end

        // Overflow: ninth byte dropped
        for (int i = 0; i < 9; i++) push(8'(i));
        chk("ovf_full", 32'(full), 32'h1);
        step(1'b0, 8'h00, 1'b1, 2'd2, 4'd3, 1'b0);
        drain(); idle(2);

        // Empty request, then requests and writes while busy
        step(1'b0, 8'h00, 1'b1, 2'd1, 4'd1, 1'b0);
        chk("empty_busy", 32'(busy), 32'h0);
        idle(2);
        push(8'hA0); push(8'hA1); push(8'hA2);
        step(1'b1, 8'hB0, 1'b1, 2'd3, 4'd5, 1'b0);
        step(1'b1, 8'hB1, 1'b1, 2'd0, 4'd6, 1'b0);
        step(1'b0, 8'h00, 1'b1, 2'd0, 4'd6, 1'b0);
        drain();
        step(1'b0, 8'h00, 1'b1, 2'd2, 4'd7, 1'b0);
        drain(); idle(2);

        // Reset during the second body flit
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        step(1'b0, 8'h00, 1'b1, 2'd1, 4'd2, 1'b0);
        idle(2);
        step(1'b0, 8'h00, 1'b0, 2'd0, 4'd0, 1'b1);
        chk("mid_rst_pkt", 32'(pkt), 32'h0);
        chk("mid_rst_busy", 32'(busy), 32'h0);
        step(1'b0, 8'h00, 1'b1, 2'd1, 4'd2, 1'b0);
        idle(3);

        // Pointer wrap with repeated 5-byte packets
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 5; i++) push(8'(k * 16 + i));
            step(1'b0, 8'h00, 1'b1, 2'(k), 4'(k + 8), 1'b0);
            drain();
        end

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 4) == 0),
                 2'($urandom), 4'($urandom), ($urandom_range(0, 149) == 0));
        end
        drain(); idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
